// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the fetch port, the memory-stage port and the
// shared memory bus that mem_bus_arbiter sits between.
// slave  = arbiter view (takes requests, drives the bus).
// master = environment view (fetch/mem stages plus the bus target).
// Strobe width is DATA_W/8. The arbiter slices the 32-bit fetch word out of
// a 64-bit beat, so DATA_W is expected to stay at 64.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_ok;
    logic [31:0]       iresp_data;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [DATA_W-1:0] dreq_wdata;
    logic              dresp_ok;
    logic [DATA_W-1:0] dresp_data;

    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [2:0]        bus_size;
    logic [STRB_W-1:0] bus_strobe;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        output dresp_ok, dresp_data,
        output bus_valid, bus_addr, bus_size, bus_strobe, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        input  dresp_ok, dresp_data,
        input  bus_valid, bus_addr, bus_size, bus_strobe, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory bus between instruction fetch
// (read-only I-port) and the memory stage (D-port). One transaction is in
// flight at a time, sequenced IDLE -> WAITING -> OVER -> IDLE.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the D-port always wins.
module mem_bus_arbiter (
    input  logic                clk,
    input  logic                reset_n,
    mem_bus_arbiter_if.slave    port_if
);
    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        OVER
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t state;
    state_t state_nxt;
    owner_t owner;
    logic   abort;

    logic   grant_i;
    logic   grant_d;
    logic   owner_valid;
    logic   complete;
    logic   deliver;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: any request in IDLE starts a bus access; OVER always
    // returns to IDLE so a held request is not reissued in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (port_if.ireq_valid || port_if.dreq_valid) state_nxt = WAITING;
            WAITING: if (port_if.bus_ready) state_nxt = OVER;
            OVER:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant decision and completion qualifiers.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (port_if.ireq_valid && port_if.dreq_valid) begin
                if (last_grant == OWN_D) grant_i = 1'b1;
                else                     grant_d = 1'b1;
            end else begin
                grant_i = port_if.ireq_valid;
                grant_d = port_if.dreq_valid;
            end
`else
            grant_d = port_if.dreq_valid;
            grant_i = port_if.ireq_valid && !port_if.dreq_valid;
`endif
        end
        owner_valid = (owner == OWN_I) ? port_if.ireq_valid : port_if.dreq_valid;
        complete    = (state == WAITING) && port_if.bus_ready;
        // A request withdrawn at any point while WAITING (including the
        // completion cycle) gets no response pulse.
        deliver     = complete && owner_valid && !abort;
    end

    // Datapath: bus request latching, flush tracking and registered responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner              <= OWN_I;
            abort              <= 1'b0;
            port_if.bus_valid  <= 1'b0;
            port_if.bus_addr   <= '0;
            port_if.bus_size   <= '0;
            port_if.bus_strobe <= '0;
            port_if.bus_wdata  <= '0;
            port_if.iresp_ok   <= 1'b0;
            port_if.iresp_data <= '0;
            port_if.dresp_ok   <= 1'b0;
            port_if.dresp_data <= '0;
        end else begin
            port_if.iresp_ok <= 1'b0;
            port_if.dresp_ok <= 1'b0;

            if (grant_d) begin
                owner              <= OWN_D;
                port_if.bus_valid  <= 1'b1;
                port_if.bus_addr   <= port_if.dreq_addr;
                port_if.bus_size   <= port_if.dreq_size;
                port_if.bus_strobe <= port_if.dreq_strobe;
                port_if.bus_wdata  <= port_if.dreq_wdata;
            end else if (grant_i) begin
                owner              <= OWN_I;
                port_if.bus_valid  <= 1'b1;
                port_if.bus_addr   <= port_if.ireq_addr;
                port_if.bus_size   <= 3'b010;
                port_if.bus_strobe <= '0;
                port_if.bus_wdata  <= '0;
            end

            if (state == OVER) begin
                abort <= 1'b0;
            end else if ((state == WAITING) && !owner_valid) begin
                abort <= 1'b1;
            end

            if (complete) begin
                port_if.bus_valid <= 1'b0;
                if (owner == OWN_I) begin
                    port_if.iresp_data <= port_if.bus_addr[2] ? port_if.bus_rdata[63:32]
                                                              : port_if.bus_rdata[31:0];
                    port_if.iresp_ok   <= deliver;
                end else begin
                    port_if.dresp_data <= port_if.bus_rdata;
                    port_if.dresp_ok   <= deliver;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin history: remembers the port granted most recently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWN_D;
        end else if (grant_d) begin
            last_grant <= OWN_D;
        end else if (grant_i) begin
            last_grant <= OWN_I;
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors plus hand-written sequences for the
// arbiter. A bus target process answers each request after a programmable
// delay and records what was put on the bus; a monitor counts response pulses.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) arb ();

    mem_bus_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .port_if (arb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus target
    logic        rsp_ready = 1'b0;
    logic        stray_ready = 1'b0;
    logic [63:0] rsp_rdata = '0;
    logic [63:0] rsp_data_cfg = '0;
    int          rsp_delay = 1;
    int          unstable_cnt = 0;
    logic [63:0] cap_addr[$];
    logic [2:0]  cap_size[$];
    logic [7:0]  cap_strobe[$];
    logic [63:0] cap_wdata[$];
    int          cap_cyc[$];
    int          rdy_cyc[$];

    assign arb.bus_ready = rsp_ready | stray_ready;
    assign arb.bus_rdata = rsp_rdata;

    initial begin
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset_n && arb.bus_valid) begin
                cap_addr.push_back(arb.bus_addr);
                cap_size.push_back(arb.bus_size);
                cap_strobe.push_back(arb.bus_strobe);
                cap_wdata.push_back(arb.bus_wdata);
                cap_cyc.push_back(cyc);
                aborted = 1'b0;
                for (int k = 0; k < rsp_delay; k++) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!arb.bus_valid || arb.bus_addr !== cap_addr[$] || arb.bus_size !== cap_size[$] ||
                        arb.bus_strobe !== cap_strobe[$] || arb.bus_wdata !== cap_wdata[$])
                        unstable_cnt++;
                end
                if (!aborted) begin
                    rsp_ready = 1'b1;
                    rsp_rdata = rsp_data_cfg;
                    rdy_cyc.push_back(cyc);
                    @(negedge clk);
                    rsp_ready = 1'b0;
                end
            end
        end
    end

    // Response monitor
    int i_ok_cnt = 0;
    int d_ok_cnt = 0;
    int i_ok_cyc = 0;
    int d_ok_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (arb.iresp_ok) begin
                i_ok_cnt++;
                i_ok_cyc = cyc;
            end
            if (arb.dresp_ok) begin
                d_ok_cnt++;
                d_ok_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          is_d;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        logic [2:0]  exp_size;
        logic [7:0]  exp_strobe;
        logic [63:0] exp_data;
    } vec_t;

    // One request on one port, held until its response pulse.
    task automatic run_vec(input vec_t v, input string tag);
        int n0, nr, ni, nd, req_cyc;
        bit got;
        n0 = cap_addr.size();
        nr = rdy_cyc.size();
        ni = i_ok_cnt;
        nd = d_ok_cnt;
        rsp_delay = v.delay;
        rsp_data_cfg = v.rdata;
        @(negedge clk);
        req_cyc = cyc;
        if (v.is_d) begin
            arb.dreq_addr   = v.addr;
            arb.dreq_size   = v.size;
            arb.dreq_strobe = v.strobe;
            arb.dreq_wdata  = v.wdata;
            arb.dreq_valid  = 1'b1;
        end else begin
            arb.ireq_addr  = v.addr;
            arb.ireq_valid = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((v.is_d && arb.dresp_ok) || (!v.is_d && arb.iresp_ok)) begin
                got = 1'b1;
                break;
            end
        end
        arb.ireq_valid = 1'b0;
        arb.dreq_valid = 1'b0;
        settle(4);
        chk({tag, " resp_ok_seen"}, 64'(got), 64'd1);
        chk({tag, " bus_txn_count"}, 64'(cap_addr.size()), 64'(n0 + 1));
        if (cap_addr.size() > n0) begin
            chk({tag, " bus_addr"}, cap_addr[n0], v.addr);
            chk({tag, " bus_size"}, 64'(cap_size[n0]), 64'(v.exp_size));
            chk({tag, " bus_strobe"}, 64'(cap_strobe[n0]), 64'(v.exp_strobe));
            if (v.is_d) chk({tag, " bus_wdata"}, cap_wdata[n0], v.wdata);
            chk({tag, " bus_valid_latency"}, 64'(cap_cyc[n0]), 64'(req_cyc + 1));
        end
        if (rdy_cyc.size() > nr) begin
            chk({tag, " resp_latency"}, 64'(v.is_d ? d_ok_cyc : i_ok_cyc), 64'(rdy_cyc[nr] + 1));
        end
        chk({tag, " iresp_ok_count"}, 64'(i_ok_cnt - ni), v.is_d ? 64'd0 : 64'd1);
        chk({tag, " dresp_ok_count"}, 64'(d_ok_cnt - nd), v.is_d ? 64'd1 : 64'd0);
        if (v.is_d) chk({tag, " dresp_data"}, arb.dresp_data, v.exp_data);
        else        chk({tag, " iresp_data"}, 64'(arb.iresp_data), v.exp_data);
    endtask

    // Requester that holds valid until its own response pulse.
    task automatic req_port(input bit is_d, input logic [63:0] addr, output bit got);
        got = 1'b0;
        if (is_d) begin
            arb.dreq_addr   = addr;
            arb.dreq_size   = 3'b011;
            arb.dreq_strobe = 8'h00;
            arb.dreq_wdata  = '0;
            arb.dreq_valid  = 1'b1;
        end else begin
            arb.ireq_addr  = addr;
            arb.ireq_valid = 1'b1;
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((is_d && arb.dresp_ok) || (!is_d && arb.iresp_ok)) begin
                got = 1'b1;
                break;
            end
        end
        if (is_d) arb.dreq_valid = 1'b0;
        else      arb.ireq_valid = 1'b0;
    endtask

    vec_t vecs[7];
    vec_t fetch_after;
    logic [63:0] exp_ab[2];
    logic [63:0] exp_b[4];
    int exp_b_i, exp_b_d;

    initial begin
        int n0, nr, ni, nd, seen;
        bit got, got_i, got_d, saw;

        vecs[0] = '{1'b0, 64'h8000_0004, 3'b000, 8'h00, 64'h0, 64'h1111_2222_3333_4444, 3, 3'b010, 8'h00, 64'h1111_2222};
        vecs[1] = '{1'b0, 64'h8000_0000, 3'b000, 8'h00, 64'h0, 64'h1111_2222_3333_4444, 1, 3'b010, 8'h00, 64'h3333_4444};
        vecs[2] = '{1'b1, 64'h0000_0100, 3'b010, 8'h0F, 64'hDEAD_BEEF, 64'h5A5A_5A5A_A5A5_A5A5, 1, 3'b010, 8'h0F, 64'h5A5A_5A5A_A5A5_A5A5};
        vecs[3] = '{1'b1, 64'h0000_0208, 3'b011, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 2, 3'b011, 8'h00, 64'hCAFE_F00D_1234_5678};
        vecs[4] = '{1'b1, 64'h0000_03F8, 3'b011, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 4, 3'b011, 8'hFF, 64'h0};
        vecs[5] = '{1'b0, 64'h0000_1010, 3'b000, 8'h00, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2, 3'b010, 8'h00, 64'hCCCC_DDDD};
        vecs[6] = '{1'b1, 64'h0000_0007, 3'b000, 8'h00, 64'h0, 64'h0000_0000_0000_00EE, 1, 3'b000, 8'h00, 64'hEE};
        fetch_after = '{1'b0, 64'h8000_0104, 3'b000, 8'h00, 64'h0, 64'h7777_6666_5555_4444, 2, 3'b010, 8'h00, 64'h7777_6666};

`ifdef MEM_ARB_RR_EN
        exp_ab = '{64'h8000_0300, 64'h0000_0500};
        exp_b  = '{64'h8000_0200, 64'h0000_0600, 64'h8000_0200, 64'h0000_0600};
        exp_b_i = 2;
        exp_b_d = 2;
`else
        exp_ab = '{64'h0000_0500, 64'h8000_0300};
        exp_b  = '{64'h0000_0600, 64'h0000_0600, 64'h0000_0600, 64'h0000_0600};
        exp_b_i = 0;
        exp_b_d = 4;
`endif

        arb.ireq_valid = 1'b0;
        arb.ireq_addr = '0;
        arb.dreq_valid = 1'b0;
        arb.dreq_addr = '0;
        arb.dreq_size = '0;
        arb.dreq_strobe = '0;
        arb.dreq_wdata = '0;

        // Reset state
        settle(3);
        chk("reset bus_valid", 64'(arb.bus_valid), 64'd0);
        chk("reset bus_addr", arb.bus_addr, 64'd0);
        chk("reset iresp_ok", 64'(arb.iresp_ok), 64'd0);
        chk("reset dresp_ok", 64'(arb.dresp_ok), 64'd0);
        chk("reset dresp_data", arb.dresp_data, 64'd0);
        reset_n = 1'b1;
        settle(2);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // bus_ready outside WAITING is ignored
        ni = i_ok_cnt;
        nd = d_ok_cnt;
        n0 = cap_addr.size();
        @(negedge clk);
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        settle(4);
        chk("stray_ready ok_pulses", 64'((i_ok_cnt - ni) + (d_ok_cnt - nd)), 64'd0);
        chk("stray_ready bus_txns", 64'(cap_addr.size()), 64'(n0));

        // Fetch flushed one cycle after bus_valid: bus completes, no iresp_ok
        ni = i_ok_cnt;
        nr = rdy_cyc.size();
        rsp_delay = 4;
        rsp_data_cfg = 64'h9999_8888_7777_6666;
        @(negedge clk);
        arb.ireq_addr = 64'h8000_0040;
        arb.ireq_valid = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (arb.bus_valid) begin
                saw = 1'b1;
                break;
            end
        end
        @(negedge clk);
        arb.ireq_valid = 1'b0;
        settle(10);
        chk("flush bus_valid_seen", 64'(saw), 64'd1);
        chk("flush bus_completed", 64'(rdy_cyc.size()), 64'(nr + 1));
        chk("flush iresp_ok_suppressed", 64'(i_ok_cnt - ni), 64'd0);
        run_vec(fetch_after, "after_flush");

        // D held across two transactions: >=2 idle bus cycles between, 2 pulses
        nd = d_ok_cnt;
        n0 = cap_addr.size();
        nr = rdy_cyc.size();
        rsp_delay = 1;
        rsp_data_cfg = 64'h1234;
        @(negedge clk);
        arb.dreq_addr = 64'h0000_0700;
        arb.dreq_size = 3'b011;
        arb.dreq_strobe = 8'h00;
        arb.dreq_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (arb.dresp_ok) seen++;
            if (seen >= 2) break;
        end
        arb.dreq_valid = 1'b0;
        settle(4);
        chk("dheld dresp_ok_count", 64'(d_ok_cnt - nd), 64'd2);
        if (cap_cyc.size() >= n0 + 2 && rdy_cyc.size() > nr)
            chk("dheld next_bus_valid_gap", 64'(cap_cyc[n0 + 1] - rdy_cyc[nr]), 64'd3);
        else
            chk("dheld bus_txn_count", 64'(cap_cyc.size()), 64'(n0 + 2));

        // Both valid together, each drops after its own response
        reset_pulse();
        n0 = cap_addr.size();
        rsp_delay = 1;
        @(negedge clk);
        fork
            req_port(1'b1, 64'h0000_0500, got_d);
            req_port(1'b0, 64'h8000_0300, got_i);
        join
        settle(4);
        chk("both got_d", 64'(got_d), 64'd1);
        chk("both got_i", 64'(got_i), 64'd1);
        if (cap_addr.size() >= n0 + 2) begin
            chk("both first_grant", cap_addr[n0], exp_ab[0]);
            chk("both second_grant", cap_addr[n0 + 1], exp_ab[1]);
        end else begin
            chk("both bus_txn_count", 64'(cap_addr.size()), 64'(n0 + 2));
        end

        // Both held continuously for four transactions
        reset_pulse();
        n0 = cap_addr.size();
        ni = i_ok_cnt;
        nd = d_ok_cnt;
        rsp_delay = 1;
        @(negedge clk);
        arb.ireq_addr = 64'h8000_0200;
        arb.dreq_addr = 64'h0000_0600;
        arb.ireq_valid = 1'b1;
        arb.dreq_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            seen += int'(arb.iresp_ok) + int'(arb.dresp_ok);
            if (seen >= 4) break;
        end
        arb.ireq_valid = 1'b0;
        arb.dreq_valid = 1'b0;
        settle(4);
        chk("held4 resp_count", 64'(seen), 64'd4);
        chk("held4 iresp_ok_count", 64'(i_ok_cnt - ni), 64'(exp_b_i));
        chk("held4 dresp_ok_count", 64'(d_ok_cnt - nd), 64'(exp_b_d));
        if (cap_addr.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("held4 grant%0d", k), cap_addr[n0 + k], exp_b[k]);
        end else begin
            chk("held4 bus_txn_count", 64'(cap_addr.size()), 64'(n0 + 4));
        end

        // Asynchronous reset while WAITING, then a normal fetch
        rsp_delay = 10;
        @(negedge clk);
        arb.dreq_addr = 64'h0000_0400;
        arb.dreq_size = 3'b011;
        arb.dreq_strobe = 8'hFF;
        arb.dreq_wdata = 64'h5555;
        arb.dreq_valid = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (arb.bus_valid) begin
                saw = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset bus_valid_before", 64'(saw), 64'd1);
        chk("async_reset bus_valid", 64'(arb.bus_valid), 64'd0);
        chk("async_reset bus_addr", arb.bus_addr, 64'd0);
        chk("async_reset iresp_ok", 64'(arb.iresp_ok), 64'd0);
        chk("async_reset dresp_ok", 64'(arb.dresp_ok), 64'd0);
        chk("async_reset iresp_data", 64'(arb.iresp_data), 64'd0);
        chk("async_reset dresp_data", arb.dresp_data, 64'd0);
        arb.dreq_valid = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        run_vec(fetch_after, "after_reset");

        chk("bus_outputs_stable", 64'(unstable_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
